// File: rtl/relop_arbiter.sv
// Round-robin arbiter sharing one registered unsigned relational-compare unit
// (LT/GT/LE/GE) among NREQ requesters; result held until the consumer accepts it.
module relop_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int CNTW  = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_result,
    output logic                   busy,
    output logic [CNTW-1:0]        done_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    localparam logic [1:0] OP_LT = 2'b00;
    localparam logic [1:0] OP_GT = 2'b01;
    localparam logic [1:0] OP_LE = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_result_q, rsp_result_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW:0]       scan_idx;
    logic               cmp_res;

    // Rotating priority scan: rr_ptr first, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!gnt_found && req_valid[scan_idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        case (op_q)
            OP_LT:   cmp_res = (a_q <  b_q);
            OP_GT:   cmp_res = (a_q >  b_q);
            OP_LE:   cmp_res = (a_q <= b_q);
            default: cmp_res = (a_q >= b_q);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so no handshake is advertised.
                if (gnt_found && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    op_d    = req_op[2*gnt_idx +: 2];
                    a_d     = req_a[WIDTH*gnt_idx +: WIDTH];
                    b_d     = req_b[WIDTH*gnt_idx +: WIDTH];
                    id_d    = gnt_idx;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rsp_result_d = cmp_res;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                    rr_ptr_d    = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 1'b0;
            rsp_id_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);
    assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_relop_arbiter.sv
// Scoreboard bench for relop_arbiter: directed requests push expected {id,result};
// a negedge monitor pops and compares on every accepted response.
module tb_relop_arbiter;

    localparam int NREQ = 4;
    localparam int WIDTH = 3;
    localparam int CNTW = 4;  // narrow counter so the wrap is reachable quickly
    localparam logic [1:0] LT = 2'b00, GT = 2'b01, LE = 2'b10, GE = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready, rsp_result, busy;
    logic [1:0]            rsp_id;
    logic [CNTW-1:0]       done_cnt;

    relop_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int res; } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    logic [CNTW-1:0] exp_cnt = '0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = '0;
            sb.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_rsp");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", int'(rsp_id), e.id);
                check("rsp_result", int'(rsp_result), e.res);
                check("done_cnt", int'(done_cnt), int'(exp_cnt));
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    task automatic push(input int id, input int res);
        exp_t e;
        e.id = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input int a, input int b);
        req_op[2*i +: 2] = op;
        req_a[WIDTH*i +: WIDTH] = WIDTH'(a);
        req_b[WIDTH*i +: WIDTH] = WIDTH'(b);
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_hs(input int i);
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) ok = 1;
        end
        if (!ok) timeout($sformatf("grant%0d", i));
        else check($sformatf("grant%0d_onehot", i), int'(req_ready), 1 << i);
    endtask

    task automatic wait_any_hs();
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) ok = 1;
        end
        if (!ok) timeout("grant_any");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) timeout("idle");
    endtask

    task automatic do_req(input int i, input logic [1:0] op, input int a, input int b, input int res);
        @(posedge clk); #1;
        set_req(i, op, a, b);
        push(i, res);
        wait_hs(i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_cnt", int'(done_cnt), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // T1
        do_req(0, LT, 0, 5, 1);
        check("t1_done_cnt", int'(done_cnt), 1);

        // T2 on req1
        do_req(1, GT, 3, 5, 0);
        do_req(1, GT, 6, 5, 1);
        do_req(1, LE, 0, 0, 1);
        do_req(1, LE, 6, 5, 0);
        do_req(1, GE, 7, 5, 1);
        do_req(1, GE, 1, 5, 0);
        do_req(1, LT, 7, 5, 0);
        do_req(3, GE, 4, 4, 1);  // leaves rr_ptr at 0

        // T3 fairness, all requesters held
        @(posedge clk); #1;
        set_req(0, LT, 1, 2);
        set_req(1, GT, 1, 2);
        set_req(2, LE, 4, 4);
        set_req(3, GE, 2, 3);
        push(0, 1); push(1, 0); push(2, 1); push(3, 0); push(0, 1); push(1, 0);
        for (int g = 0; g < 6; g++) wait_any_hs();
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // T4 backpressure on req1 while req3 waits
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(1, GT, 5, 2);
        push(1, 1);
        wait_hs(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(3, LT, 0, 1);
        begin
            bit ok = 0;
            for (int c = 0; c < 10 && !ok; c++) begin
                @(negedge clk);
                if (rsp_valid) ok = 1;
            end
            if (!ok) timeout("t4_rsp_valid");
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("t4_valid", int'(rsp_valid), 1);
            check("t4_id", int'(rsp_id), 1);
            check("t4_result", int'(rsp_result), 1);
            check("t4_req_ready", int'(req_ready), 0);
            check("t4_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_release", int'(rsp_valid), 0);
        check("t4_idle", int'(busy), 0);

        // T5 reset during EVAL; rr_ptr is 2 beforehand
        @(posedge clk); #1;
        set_req(3, LT, 1, 6);
        wait_hs(3);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("t5_rsp_valid", int'(rsp_valid), 0);
        check("t5_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, LE, 3, 3);
        set_req(2, GT, 3, 3);
        push(0, 1); push(2, 0);
        wait_any_hs();
        check("t5_first_grant", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_hs(2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_idle();

        // T6: 2 completions since reset, 14 more reaches 16 -> counter wraps to 0
        for (int k = 0; k < 14; k++)
            do_req(k % 4, GE, k % 8, 3, ((k % 8) >= 3) ? 1 : 0);
        check("t6_wrap", int'(done_cnt), 0);

        begin
            bit ok = 0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                if (sb.size() == 0) ok = 1;
            end
            if (!ok) timeout("scoreboard_drain");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
